// File: rtl/jtgng_vtimer.sv
// jtgng_vtimer: arcade video timing generator with H/V counters,
// blanking, syncs, line/frame strobes and a colour-bar test source.
module jtgng_vtimer #(
    parameter int H_TOTAL  = 384,
    parameter int HB_START = 256,
    parameter int HS_START = 288,
    parameter int HS_END   = 320,
    parameter int V_TOTAL  = 262,
    parameter int VB_START = 224,
    parameter int VS_START = 240,
    parameter int VS_END   = 243
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cen,
    input  logic       pattern_en,
    output logic [8:0] H,
    output logic [8:0] V,
    output logic       LHBL,
    output logic       LVBL,
    output logic       HS,
    output logic       VS,
    output logic       hinit,
    output logic       vinit,
    output logic [3:0] red,
    output logic [3:0] green,
    output logic [3:0] blue
);

    localparam logic [8:0] H_LAST = 9'(H_TOTAL - 1);
    localparam logic [8:0] V_LAST = 9'(V_TOTAL - 1);
    localparam logic [9:0] HB_L   = 10'(HB_START);
    localparam logic [9:0] HSS_L  = 10'(HS_START);
    localparam logic [9:0] HSE_L  = 10'(HS_END);
    localparam logic [9:0] VB_L   = 10'(VB_START);
    localparam logic [9:0] VSS_L  = 10'(VS_START);
    localparam logic [9:0] VSE_L  = 10'(VS_END);
    localparam logic [9:0] BAR_W  = 10'(HB_START / 8);

    logic       h_wrap;
    logic       v_wrap;
    logic [8:0] h_nxt;
    logic [8:0] v_nxt;
    logic [9:0] h_ext;
    logic [9:0] v_ext;
    logic       act_nxt;
    logic [2:0] idx;

    // Next counts and the decode of the position they will present
    always_comb begin
        h_wrap  = (H == H_LAST);
        v_wrap  = (V == V_LAST);
        h_nxt   = h_wrap ? 9'd0 : H + 9'd1;
        v_nxt   = V;
        if (h_wrap)
            v_nxt = v_wrap ? 9'd0 : V + 9'd1;
        h_ext   = {1'b0, h_nxt};
        v_ext   = {1'b0, v_nxt};
        act_nxt = (h_ext < HB_L) && (v_ext < VB_L);
        idx     = 3'(h_ext / BAR_W);
    end

    // Counters, decoded video signals and strobes, all on cen
    always_ff @(posedge clk) begin
        if (rst) begin
            H     <= 9'd0;
            V     <= 9'd0;
            LHBL  <= 1'b1;
            LVBL  <= 1'b1;
            HS    <= 1'b0;
            VS    <= 1'b0;
            hinit <= 1'b0;
            vinit <= 1'b0;
            red   <= 4'd0;
            green <= 4'd0;
            blue  <= 4'd0;
        end else if (cen) begin
            H     <= h_nxt;
            V     <= v_nxt;
            LHBL  <= h_ext < HB_L;
            LVBL  <= v_ext < VB_L;
            HS    <= (h_ext >= HSS_L) && (h_ext < HSE_L);
            VS    <= (v_ext >= VSS_L) && (v_ext < VSE_L);
            hinit <= h_wrap;
            vinit <= h_wrap && v_wrap;
            if (pattern_en && act_nxt) begin
                red   <= {4{idx[2]}};
                green <= {4{idx[1]}};
                blue  <= {4{idx[0]}};
            end else begin
                red   <= 4'd0;
                green <= 4'd0;
                blue  <= 4'd0;
            end
        end else begin
            hinit <= 1'b0;
            vinit <= 1'b0;
        end
    end

endmodule

// File: tb/tb_jtgng_vtimer.sv
// tb_jtgng_vtimer: scoreboard bench for two timer geometries, the
// default one and a small one whose whole frames fit in a short run.
module tb_jtgng_vtimer;

    typedef struct packed {
        logic [8:0] h;
        logic [8:0] v;
        logic       lhbl;
        logic       lvbl;
        logic       hs;
        logic       vs;
        logic       hi;
        logic       vi;
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } obs_t;

    localparam int SB_HT  = 40;
    localparam int SB_HB  = 32;
    localparam int SB_HSS = 34;
    localparam int SB_HSE = 40;
    localparam int SB_VT  = 12;
    localparam int SB_VB  = 8;
    localparam int SB_VSS = 9;
    localparam int SB_VSE = 11;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic cen = 1'b0;
    logic pattern_en = 1'b0;

    logic [8:0] ha, va, hb, vb;
    logic       lhbla, lvbla, hsa, vsa, hia, via;
    logic       lhblb, lvblb, hsb, vsb, hib, vib;
    logic [3:0] ra, ga, ba, rb, gb, bb;
    obs_t       oa, ob;

    obs_t qa[$];
    obs_t qb[$];
    int   tests = 0;
    int   fails = 0;
    int   n = 0;
    bit   pes = 1'b0;
    bit   st = 1'b0;
    int   cen_cnt = 0;
    int   hcnt = 0;
    int   frames = 0;

    always #5 clk = ~clk;

    jtgng_vtimer dut_a (
        .clk(clk), .rst(rst), .cen(cen), .pattern_en(pattern_en),
        .H(ha), .V(va), .LHBL(lhbla), .LVBL(lvbla),
        .HS(hsa), .VS(vsa), .hinit(hia), .vinit(via),
        .red(ra), .green(ga), .blue(ba)
    );

    jtgng_vtimer #(
        .H_TOTAL(SB_HT), .HB_START(SB_HB),
        .HS_START(SB_HSS), .HS_END(SB_HSE),
        .V_TOTAL(SB_VT), .VB_START(SB_VB),
        .VS_START(SB_VSS), .VS_END(SB_VSE)
    ) dut_b (
        .clk(clk), .rst(rst), .cen(cen), .pattern_en(pattern_en),
        .H(hb), .V(vb), .LHBL(lhblb), .LVBL(lvblb),
        .HS(hsb), .VS(vsb), .hinit(hib), .vinit(vib),
        .red(rb), .green(gb), .blue(bb)
    );

    assign oa = {ha, va, lhbla, lvbla, hsa, vsa, hia, via, ra, ga, ba};
    assign ob = {hb, vb, lhblb, lvblb, hsb, vsb, hib, vib, rb, gb, bb};

    // Position p = cen steps since reset, folded into one frame
    function automatic obs_t model(
        input int ht, input int hbs, input int hss, input int hse,
        input int vt, input int vbs, input int vss, input int vse,
        input int steps, input bit pe, input bit stepped
    );
        obs_t o;
        int p, h, v;
        logic [2:0] idx;
        p = steps % (ht * vt);
        h = p % ht;
        v = p / ht;
        idx = 3'(h / (hbs / 8));
        o.h = 9'(h);
        o.v = 9'(v);
        o.lhbl = (h < hbs);
        o.lvbl = (v < vbs);
        o.hs = (h >= hss) && (h < hse);
        o.vs = (v >= vss) && (v < vse);
        o.hi = stepped && (h == 0);
        o.vi = stepped && (h == 0) && (v == 0);
        if (pe && h < hbs && v < vbs) begin
            o.r = {4{idx[2]}};
            o.g = {4{idx[1]}};
            o.b = {4{idx[0]}};
        end else begin
            o.r = 4'd0;
            o.g = 4'd0;
            o.b = 4'd0;
        end
        return o;
    endfunction

    task automatic tick(input bit r, input bit c, input bit pe);
        #1;
        rst = r;
        cen = c;
        pattern_en = pe;
        @(posedge clk);
        if (r) begin
            n = 0;
            pes = 1'b0;
            st = 1'b0;
            cen_cnt = 0;
            hcnt = 0;
        end else if (c) begin
            n++;
            pes = pe;
            st = 1'b1;
            cen_cnt++;
        end else begin
            st = 1'b0;
        end
        qa.push_back(model(384, 256, 288, 320, 262, 224, 240, 243,
                           n, pes, st));
        qb.push_back(model(SB_HT, SB_HB, SB_HSS, SB_HSE,
                           SB_VT, SB_VB, SB_VSS, SB_VSE, n, pes, st));
    endtask

    task automatic check(input string nm, input obs_t got, input obs_t exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s t=%0t got h=%0d v=%0d f=%b rgb=%h%h%h exp h=%0d v=%0d f=%b rgb=%h%h%h",
                nm, $time, got.h, got.v,
                {got.lhbl, got.lvbl, got.hs, got.vs, got.hi, got.vi},
                got.r, got.g, got.b, exp.h, exp.v,
                {exp.lhbl, exp.lvbl, exp.hs, exp.vs, exp.hi, exp.vi},
                exp.r, exp.g, exp.b);
        end
    endtask

    // Monitor: pop one expectation per presented cycle and compare
    always @(negedge clk) begin
        obs_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("geomA", oa, e);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("geomB", ob, e);
            if (ob.hi) hcnt++;
            if (ob.vi) begin
                frames++;
                tests++;
                if (hcnt != SB_VT) begin
                    fails++;
                    $display("FAIL lines_per_frame got %0d exp %0d",
                             hcnt, SB_VT);
                end
                tests++;
                if (cen_cnt != SB_HT * SB_VT) begin
                    fails++;
                    $display("FAIL cen_per_frame got %0d exp %0d",
                             cen_cnt, SB_HT * SB_VT);
                end
                hcnt = 0;
                cen_cnt = 0;
            end
        end
    end

    initial begin
        bit pe;
        bit reached;
        pe = 1'b1;
        repeat (3) tick(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2000; i++)
            tick(1'b0, (i % 4) == 3, 1'b1);
        for (int i = 0; i < 1200; i++)
            tick(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(0, 299) == 0) pe = ~pe;
            tick($urandom_range(0, 2999) == 0,
                 1'($urandom_range(0, 1)), pe);
        end
        tick(1'b1, 1'b0, 1'b1);
        reached = 1'b0;
        for (int i = 0; i < 60000 && !reached; i++) begin
            if (n == 150 * 384 + 100) reached = 1'b1;
            else tick(1'b0, 1'b1, 1'b1);
        end
        tests++;
        if (!reached) begin
            fails++;
            $display("FAIL reach_h100_v150 got n=%0d exp %0d",
                     n, 150 * 384 + 100);
        end
        tick(1'b1, 1'b1, 1'b1);
        repeat (3) tick(1'b0, 1'b0, 1'b1);
        repeat (200) tick(1'b0, 1'b1, 1'b1);
        repeat (50) tick(1'b0, 1'b0, 1'b1);
        repeat (300) tick(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 199) == 0) pe = ~pe;
            tick(1'b0, 1'($urandom_range(0, 3) != 0), pe);
        end
        @(negedge clk);
        @(negedge clk);
        tests++;
        if (frames < 2) begin
            fails++;
            $display("FAIL frames_seen got %0d exp >=2", frames);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
